// File: rtl/kmeans_assign_pipe.sv
// kmeans_assign_pipe: streaming nearest-centroid assignment.
// Each accepted point is compared against every stored centroid. The pipeline is
// one difference stage, one square stage, a registered adder tree over the
// dimensions and a registered compare tree over the centroids. The last compare
// stage is the output register. Latency is 2 + clog2(DIMS) + clog2(CENTROIDS).
// Handshake: in_valid qualifies in_data in the cycle it is high. There is no
// ready/backpressure, so every in_valid sample is accepted. out_valid qualifies
// out_data/out_idx/out_dist for exactly one cycle per accepted sample.
// Optional feature: define KMEANS_ACCUM_EN to add per-centroid sum/count
// accumulators and the acc_* ports.
module kmeans_assign_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int DIMS       = 5,
  parameter int CENTROIDS  = 3,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W  = ($clog2(CENTROIDS) < 1) ? 1 : $clog2(CENTROIDS),
  localparam int DIST_W = 2 * DATA_WIDTH + $clog2(DIMS),
  localparam int VW     = DIMS * DATA_WIDTH,
  localparam int SUM_W  = DATA_WIDTH + CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cent_we,
  input  logic [IDX_W-1:0]     cent_idx,
  input  logic [VW-1:0]        cent_data,
  input  logic                 in_valid,
  input  logic [VW-1:0]        in_data,
  output logic                 out_valid,
  output logic [VW-1:0]        out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic [DIST_W-1:0]    out_dist,
`ifdef KMEANS_ACCUM_EN
  input  logic                 acc_clr,
  input  logic [IDX_W-1:0]     acc_rd_idx,
  output logic [DIMS*SUM_W-1:0] acc_sum,
  output logic [CNT_WIDTH-1:0] acc_cnt,
  output logic                 acc_ovf,
`endif
  output logic                 busy
);

  localparam int LOG_D = $clog2(DIMS);
  localparam int LOG_C = $clog2(CENTROIDS);
  localparam int LAT   = 2 + LOG_D + LOG_C;

  // Number of live operands at a given tree level.
  function automatic int lvl_cnt(input int total, input int lvl);
    return (total + (1 << lvl) - 1) >> lvl;
  endfunction

  // Exact square of a signed difference; magnitude < 2^DATA_WIDTH so it fits 2*DATA_WIDTH bits.
  function automatic logic [DIST_W-1:0] sq_f(input logic signed [DATA_WIDTH:0] a);
    logic signed [2*DATA_WIDTH+1:0] w;
    w = a;
    w = w * w;
    return DIST_W'(w);
  endfunction

  logic [VW-1:0]                cent_q [CENTROIDS];
  logic signed [DATA_WIDTH:0]   diff_q [CENTROIDS][DIMS];
  logic [DIST_W-1:0]            tree_q [LOG_D+1][CENTROIDS][DIMS];
  logic [DIST_W-1:0]            cmp_d_q [LOG_C][CENTROIDS];
  logic [IDX_W-1:0]             cmp_i_q [LOG_C][CENTROIDS];
  logic [DIST_W-1:0]            src_d [LOG_C+1][CENTROIDS];
  logic [IDX_W-1:0]             src_i [LOG_C+1][CENTROIDS];
  logic [LAT-1:0]               vld_q;
  logic [VW-1:0]                data_q [LAT];

  // Centroid registers; out-of-range indices match no entry and are dropped.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CENTROIDS; c++) begin
      if (!rst_n)
        cent_q[c] <= '0;
      else if (cent_we && cent_idx == IDX_W'(c))
        cent_q[c] <= cent_data;
    end
  end

  // Valid shift register and delayed point; each stage moves only with its valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) data_q[s] <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], in_valid};
      if (in_valid) data_q[0] <= in_data;
      for (int s = 1; s < LAT; s++)
        if (vld_q[s-1]) data_q[s] <= data_q[s-1];
    end
  end

  // Differences against current centroids, squares, then the adder tree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CENTROIDS; c++)
        for (int d = 0; d < DIMS; d++) begin
          diff_q[c][d] <= '0;
          for (int l = 0; l <= LOG_D; l++) tree_q[l][c][d] <= '0;
        end
    end else begin
      for (int c = 0; c < CENTROIDS; c++)
        for (int d = 0; d < DIMS; d++) begin
          if (in_valid)
            diff_q[c][d] <= $signed({1'b0, in_data[d*DATA_WIDTH +: DATA_WIDTH]})
                          - $signed({1'b0, cent_q[c][d*DATA_WIDTH +: DATA_WIDTH]});
          if (vld_q[0])
            tree_q[0][c][d] <= sq_f(diff_q[c][d]);
        end
      for (int l = 0; l < LOG_D; l++)
        if (vld_q[1+l])
          for (int c = 0; c < CENTROIDS; c++)
            for (int j = 0; j < DIMS; j++) begin
              if (2*j+1 < lvl_cnt(DIMS, l))
                tree_q[l+1][c][j] <= tree_q[l][c][2*j] + tree_q[l][c][2*j+1];
              else if (2*j < lvl_cnt(DIMS, l))
                tree_q[l+1][c][j] <= tree_q[l][c][2*j];
              else
                tree_q[l+1][c][j] <= '0;
            end
    end
  end

  // Compare tree inputs: level 0 is the per-centroid distance, higher levels the registers.
  always_comb begin
    for (int k = 0; k <= LOG_C; k++)
      for (int c = 0; c < CENTROIDS; c++) begin
        src_d[k][c] = '0;
        src_i[k][c] = '0;
      end
    for (int c = 0; c < CENTROIDS; c++) begin
      src_d[0][c] = tree_q[LOG_D][c][0];
      src_i[0][c] = IDX_W'(c);
      for (int k = 1; k <= LOG_C; k++) begin
        src_d[k][c] = cmp_d_q[k-1][c];
        src_i[k][c] = cmp_i_q[k-1][c];
      end
    end
  end

  // Registered compare tree; the left (lower index) operand wins ties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < LOG_C; k++)
        for (int c = 0; c < CENTROIDS; c++) begin
          cmp_d_q[k][c] <= '0;
          cmp_i_q[k][c] <= '0;
        end
    end else begin
      for (int k = 0; k < LOG_C; k++)
        if (vld_q[1+LOG_D+k])
          for (int j = 0; j < CENTROIDS; j++) begin
            if (2*j+1 < lvl_cnt(CENTROIDS, k)) begin
              if (src_d[k][2*j+1] < src_d[k][2*j]) begin
                cmp_d_q[k][j] <= src_d[k][2*j+1];
                cmp_i_q[k][j] <= src_i[k][2*j+1];
              end else begin
                cmp_d_q[k][j] <= src_d[k][2*j];
                cmp_i_q[k][j] <= src_i[k][2*j];
              end
            end else if (2*j < lvl_cnt(CENTROIDS, k)) begin
              cmp_d_q[k][j] <= src_d[k][2*j];
              cmp_i_q[k][j] <= src_i[k][2*j];
            end else begin
              cmp_d_q[k][j] <= '0;
              cmp_i_q[k][j] <= '0;
            end
          end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = data_q[LAT-1];
  assign out_idx   = src_i[LOG_C][0];
  assign out_dist  = src_d[LOG_C][0];
  assign busy      = |vld_q;

`ifdef KMEANS_ACCUM_EN
  logic [SUM_W-1:0]     sum_q [CENTROIDS][DIMS];
  logic [CNT_WIDTH-1:0] cnt_q [CENTROIDS];
  logic                 ovf_q;

  // Accumulate winners; clear beats a coincident sample, a full counter drops it and flags overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || acc_clr) begin
      ovf_q <= 1'b0;
      for (int c = 0; c < CENTROIDS; c++) begin
        cnt_q[c] <= '0;
        for (int d = 0; d < DIMS; d++) sum_q[c][d] <= '0;
      end
    end else if (out_valid) begin
      for (int c = 0; c < CENTROIDS; c++)
        if (out_idx == IDX_W'(c)) begin
          if (cnt_q[c] == '1) begin
            ovf_q <= 1'b1;
          end else begin
            cnt_q[c] <= cnt_q[c] + 1'b1;
            for (int d = 0; d < DIMS; d++)
              sum_q[c][d] <= sum_q[c][d] + SUM_W'(out_data[d*DATA_WIDTH +: DATA_WIDTH]);
          end
        end
    end
  end

  // Combinational read port; out-of-range selects read zero.
  always_comb begin
    acc_sum = '0;
    acc_cnt = '0;
    for (int c = 0; c < CENTROIDS; c++)
      if (acc_rd_idx == IDX_W'(c)) begin
        acc_cnt = cnt_q[c];
        for (int d = 0; d < DIMS; d++) acc_sum[d*SUM_W +: SUM_W] = sum_q[c][d];
      end
  end

  assign acc_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_kmeans_assign_pipe.sv
// tb_kmeans_assign_pipe: directed vectors for kmeans_assign_pipe at
// DATA_WIDTH=16, DIMS=5, CENTROIDS=3. A driver pushes each sample's expected
// result and arrival edge into queues; a monitor pops and compares on out_valid.
// With KMEANS_ACCUM_EN defined the accumulator ports are also exercised.
module tb_kmeans_assign_pipe;
  localparam int L = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cent_we = 1'b0;
  logic [1:0]  cent_idx = '0;
  logic [79:0] cent_data = '0;
  logic        in_valid = 1'b0;
  logic [79:0] in_data = '0;
  logic        out_valid;
  logic [79:0] out_data;
  logic [1:0]  out_idx;
  logic [34:0] out_dist;
  logic        busy;
`ifdef KMEANS_ACCUM_EN
  logic         acc_clr = 1'b0;
  logic [1:0]   acc_rd_idx = '0;
  logic [159:0] acc_sum;
  logic [15:0]  acc_cnt;
  logic         acc_ovf;
`endif

  kmeans_assign_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .cent_we(cent_we), .cent_idx(cent_idx), .cent_data(cent_data),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_dist(out_dist),
`ifdef KMEANS_ACCUM_EN
    .acc_clr(acc_clr), .acc_rd_idx(acc_rd_idx), .acc_sum(acc_sum),
    .acc_cnt(acc_cnt), .acc_ovf(acc_ovf),
`endif
    .busy(busy)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // Scoreboard state
  logic [79:0] exp_data_q[$];
  logic [1:0]  exp_idx_q[$];
  logic [34:0] exp_dist_q[$];
  int          exp_edge_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [79:0] rep(input logic [15:0] v);
    return {5{v}};
  endfunction

  function automatic logic [79:0] vec(input logic [15:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Driver tasks: one call = one cycle of inputs, applied on the falling edge
  task automatic step(input logic we, input logic [1:0] widx, input logic [79:0] wdata,
                      input logic v, input logic [79:0] d, input logic [1:0] ei,
                      input logic [34:0] ed);
    @(negedge clk);
    cent_we = we; cent_idx = widx; cent_data = wdata;
    in_valid = v; in_data = d;
    if (v) begin
      exp_data_q.push_back(d);
      exp_idx_q.push_back(ei);
      exp_dist_q.push_back(ed);
      exp_edge_q.push_back(edge_n + L);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, '0, 1'b0, '0, 2'd0, '0);
  endtask

  task automatic wr_cent(input logic [1:0] idx, input logic [79:0] d);
    step(1'b1, idx, d, 1'b0, '0, 2'd0, '0);
  endtask

  task automatic send(input logic [79:0] d, input logic [1:0] ei, input logic [34:0] ed);
    step(1'b0, 2'd0, '0, 1'b1, d, ei, ed);
  endtask

  task automatic flush_q();
    exp_data_q.delete(); exp_idx_q.delete(); exp_dist_q.delete(); exp_edge_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_data_q.size() != 0 && n < 40) begin
      idle(1);
      n++;
    end
    chk("drain_pending", exp_data_q.size(), 0);
    flush_q();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cent_we = 1'b0; in_valid = 1'b0;
    flush_q();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_scen1();
    wr_cent(2'd0, rep(16'd0));
    wr_cent(2'd1, rep(16'd10));
    wr_cent(2'd2, rep(16'd100));
  endtask

  // Monitor: pops the expected queue on every out_valid
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (exp_data_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        chk("out_edge", out_valid ? edge_n : 0, exp_edge_q.pop_front());
        chk("out_data", out_data, exp_data_q.pop_front());
        chk("out_idx",  out_idx,  exp_idx_q.pop_front());
        chk("out_dist", out_dist, exp_dist_q.pop_front());
      end
    end
  end

  // Stimulus table for the valid-pattern test
  logic        pat  [8] = '{1, 1, 0, 1, 1, 1, 0, 1};
  logic [15:0] pv   [6] = '{16'd12, 16'd3, 16'd60, 16'd55, 16'd200, 16'd5};
  logic [1:0]  pidx [6] = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0};
  logic [34:0] pdst [6] = '{35'd20, 35'd45, 35'd8000, 35'd10125, 35'd50000, 35'd125};

  initial begin
    int k;
    repeat (3) @(negedge clk);
    do_reset();
    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_dist", out_dist, 0);

    // Scenario 1: nearest is c1
    set_scen1();
    send(rep(16'd12), 2'd1, 35'd20);
    drain();

    // Scenario 2: equal distances, lower index wins
    wr_cent(2'd0, rep(16'd5));
    wr_cent(2'd1, rep(16'd5));
    wr_cent(2'd2, rep(16'd900));
    send(rep(16'd5), 2'd0, 35'd0);
    drain();

    // Scenario 3: full-scale coordinates, wide distances
    wr_cent(2'd0, rep(16'd0));
    wr_cent(2'd1, vec(16'd65535, 16'd0, 16'd0, 16'd0, 16'd0));
    wr_cent(2'd2, rep(16'd1000));
    send(vec(16'd65535, 16'd0, 16'd0, 16'd0, 16'd0), 2'd1, 35'd0);
    send(vec(16'd65535, 16'd65535, 16'd0, 16'd0, 16'd0), 2'd1, 35'd4294836225);
    send(rep(16'd65535), 2'd1, 35'd17179344900);
    drain();

    // Out-of-range write is ignored; same-cycle write uses the old centroid
    set_scen1();
    wr_cent(2'd3, rep(16'd12));
    send(rep(16'd12), 2'd1, 35'd20);
    step(1'b1, 2'd1, rep(16'd200), 1'b1, rep(16'd12), 2'd1, 35'd20);
    send(rep(16'd12), 2'd0, 35'd720);
    drain();

    // Valid pattern 1,1,0,1,1,1,0,1 reproduced L cycles later
    wr_cent(2'd1, rep(16'd10));
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (pat[i]) begin
        send(rep(pv[k]), pidx[k], pdst[k]);
        k++;
      end else begin
        idle(1);
      end
    end
    drain();

    // Reset with samples in flight
    send(rep(16'd12), 2'd1, 35'd20);
    send(rep(16'd13), 2'd1, 35'd45);
    send(rep(16'd14), 2'd1, 35'd80);
    do_reset();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    idle(10);
    chk("post_rst_busy", busy, 0);
    send(rep(16'd7), 2'd0, 35'd245);
    drain();

`ifdef KMEANS_ACCUM_EN
    // Accumulators
    do_reset();
    set_scen1();
    repeat (4) send(rep(16'd12), 2'd1, 35'd20);
    drain();
    idle(2);
    acc_rd_idx = 2'd1;
    #1;
    chk("acc_cnt_c1", acc_cnt, 4);
    for (int d = 0; d < 5; d++) chk("acc_sum_c1", acc_sum[d*32 +: 32], 48);
    chk("acc_ovf", acc_ovf, 0);
    acc_rd_idx = 2'd0;
    #1;
    chk("acc_cnt_c0", acc_cnt, 0);
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    acc_rd_idx = 2'd1;
    #1;
    chk("acc_cnt_clr", acc_cnt, 0);
    chk("acc_sum_clr", acc_sum, 0);
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
